// File: rtl/tristate_arb_pkg.sv
// tristate_arb_pkg: shared types and helpers for the tristate bus arbiter.
//   arb_state_t : arbiter FSM state encoding.
//   rr_next     : round-robin pointer successor, wrapping modulo n.
package tristate_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_TURN  = 2'd2
  } arb_state_t;

  // Pointer successor: ptr+1, wrapping back to 0 at n.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage : tristate_arb_pkg

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req     in  N           request vector
//   ptr     in  $clog2(N)   highest-priority index for this search
//   pick    out N           one-hot winner (zero when req == 0)
//   pick_id out $clog2(N)   winner index (don't-care when req == 0)
// Rotates req so ptr lands on bit 0, takes the lowest set bit, then rotates
// the offset back into absolute index space.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         pick,
  output logic [$clog2(N)-1:0] pick_id
);

  localparam int unsigned ID_W = $clog2(N);

  logic [N-1:0]    rot_c;
  logic [ID_W-1:0] idx_c;
  logic [ID_W-1:0] off_c;
  logic            found_c;

  // Rotate, priority-encode, un-rotate.
  always_comb begin
    rot_c   = '0;
    idx_c   = '0;
    off_c   = '0;
    found_c = 1'b0;
    pick    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx_c    = ID_W'((i + 32'(ptr)) % N);
      rot_c[i] = req[idx_c];
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (rot_c[i] && !found_c) begin
        found_c = 1'b1;
        off_c   = ID_W'(i);
      end
    end
    pick_id = ID_W'((32'(off_c) + 32'(ptr)) % N);
    if (found_c) pick[pick_id] = 1'b1;
  end

endmodule : rr_pick

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: round-robin arbiter producing drive enables for a
// group of tristate buffers on one shared bus, with forced all-off
// turnaround cycles between grants.
//   clk        in  1          rising-edge clock
//   rst        in  1          asynchronous active-high reset
//   req        in  N          level-sensitive requests
//   oe         out N          registered one-hot-or-zero buffer enables
//   gnt_valid  out 1          registered, oe != 0
//   gnt_id     out $clog2(N)  registered granted index, 0 when idle
//   bus_float  out 1          registered, oe == 0 (bus at z)
// Optional feature: define TRISTATE_ARB_HOLD_LIMIT_EN to force a release
// after MAX_HOLD consecutive grant cycles.
module tristate_bus_arbiter
  import tristate_arb_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         oe,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 bus_float
);

  localparam int unsigned ID_W   = $clog2(N);
  localparam int unsigned TURN_W = $clog2(TURNAROUND + 1);

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [N-1:0]      oe_q, oe_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic              gnt_valid_q;
  logic              bus_float_q;
  logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;
  logic              arb_c;
  logic              release_c;
  logic [N-1:0]      pick_c;
  logic [ID_W-1:0]   pick_id_c;

`ifdef TRISTATE_ARB_HOLD_LIMIT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`else
  logic unused_hold_cfg;
  assign unused_hold_cfg = (MAX_HOLD == 0);
`endif

  rr_pick #(.N(N)) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .pick    (pick_c),
    .pick_id (pick_id_c)
  );

  // Next-state logic. The final turnaround edge doubles as the IDLE
  // evaluation edge, so back-to-back grants are separated by exactly
  // TURNAROUND float cycles.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    oe_d       = oe_q;
    gnt_id_d   = gnt_id_q;
    turn_cnt_d = turn_cnt_q;
    arb_c      = 1'b0;
    release_c  = 1'b0;
`ifdef TRISTATE_ARB_HOLD_LIMIT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      ARB_IDLE: arb_c = 1'b1;
      ARB_GRANT: begin
        release_c = !req[gnt_id_q];
`ifdef TRISTATE_ARB_HOLD_LIMIT_EN
        hold_cnt_d = HOLD_W'(hold_cnt_q + 1'b1);
        // Timeout coinciding with a release is just one release.
        if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) release_c = 1'b1;
`endif
        if (release_c) begin
          state_d    = ARB_TURN;
          oe_d       = '0;
          gnt_id_d   = '0;
          turn_cnt_d = '0;
        end
      end
      ARB_TURN: begin
        if (turn_cnt_q == TURN_W'(TURNAROUND - 1)) arb_c = 1'b1;
        else turn_cnt_d = TURN_W'(turn_cnt_q + 1'b1);
      end
      default: begin
        state_d  = ARB_IDLE;
        oe_d     = '0;
        gnt_id_d = '0;
      end
    endcase

    if (arb_c) begin
      turn_cnt_d = '0;
      if (|req) begin
        state_d  = ARB_GRANT;
        oe_d     = pick_c;
        gnt_id_d = pick_id_c;
        ptr_d    = ID_W'(rr_next(32'(pick_id_c), N));
`ifdef TRISTATE_ARB_HOLD_LIMIT_EN
        hold_cnt_d = '0;
`endif
      end else begin
        state_d  = ARB_IDLE;
        oe_d     = '0;
        gnt_id_d = '0;
      end
    end
  end

  // State and output registers; reset drops oe without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      oe_q        <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      bus_float_q <= 1'b1;
      turn_cnt_q  <= '0;
`ifdef TRISTATE_ARB_HOLD_LIMIT_EN
      hold_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      oe_q        <= oe_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= |oe_d;
      bus_float_q <= ~|oe_d;
      turn_cnt_q  <= turn_cnt_d;
`ifdef TRISTATE_ARB_HOLD_LIMIT_EN
      hold_cnt_q  <= hold_cnt_d;
`endif
    end
  end

  assign oe        = oe_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign bus_float = bus_float_q;

endmodule : tristate_bus_arbiter

// File: tb/tb_tristate_bus_arbiter.sv
// tb_tristate_bus_arbiter: directed self-checking bench for
// tristate_bus_arbiter (N=4, TURNAROUND=1, MAX_HOLD=16), plus a random
// phase covered by per-cycle invariant checks.
module tb_tristate_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] oe;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       bus_float;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] prev_oe = '0;

  tristate_bus_arbiter #(.N(4), .TURNAROUND(1), .MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .oe        (oe),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .bus_float (bus_float)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive req, clock once, land 1 time unit after the edge.
  task automatic cyc(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_oe(input string tag, input logic [3:0] e_oe, input logic [1:0] e_id);
    check_eq({tag, ".oe"}, 32'(oe), 32'(e_oe));
    check_eq({tag, ".id"}, 32'(gnt_id), 32'(e_id));
  endtask

  // Per-cycle invariants plus "different grants never abut".
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("inv_onehot0", 32'($onehot0(oe)), 32'd1);
      check_eq("inv_float", 32'(bus_float), 32'(oe == 4'd0));
      check_eq("inv_valid", 32'(gnt_valid), 32'(!bus_float));
      check_eq("inv_gap", 32'(prev_oe == 4'd0 || oe == 4'd0 || oe == prev_oe), 32'd1);
      prev_oe <= oe;
    end else begin
      prev_oe <= '0;
    end
  end

  initial begin
    rst = 1'b1;
    req = 4'b1111;

    // 1. Reset holds everything off even with all requests high.
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("rst.oe", 32'(oe), 32'd0);
      check_eq("rst.float", 32'(bus_float), 32'd1);
      check_eq("rst.valid", 32'(gnt_valid), 32'd0);
      check_eq("rst.id", 32'(gnt_id), 32'd0);
      @(posedge clk);
      #1;
    end
    req = 4'b0000;
    rst = 1'b0;

    // 2. Single requester: 3 grant cycles, one float, then idle.
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0001);
      expect_oe("single", 4'b0001, 2'd0);
    end
    cyc(4'b0000);
    expect_oe("single_rel", 4'b0000, 2'd0);
    check_eq("single_rel.float", 32'(bus_float), 32'd1);
    // Re-request during the float cycle: granted on the very next edge.
    cyc(4'b0001);
    expect_oe("regrant", 4'b0001, 2'd0);
    cyc(4'b0000);
    expect_oe("regrant_rel", 4'b0000, 2'd0);
    cyc(4'b0000);
    expect_oe("idle", 4'b0000, 2'd0);

    // 3. Round-robin ordering (ptr == 1 here).
    cyc(4'b0010);
    expect_oe("rr_g1", 4'b0010, 2'd1);
    cyc(4'b1010);
    expect_oe("rr_nopreempt", 4'b0010, 2'd1);
    cyc(4'b1000);
    expect_oe("rr_turn1", 4'b0000, 2'd0);
    cyc(4'b1000);
    expect_oe("rr_g3", 4'b1000, 2'd3);
    cyc(4'b1010);
    expect_oe("rr_hold3", 4'b1000, 2'd3);
    cyc(4'b0010);
    expect_oe("rr_turn3", 4'b0000, 2'd0);
    cyc(4'b0010);
    expect_oe("rr_g1b", 4'b0010, 2'd1);
    cyc(4'b0000);
    cyc(4'b0000);
    expect_oe("rr_idle", 4'b0000, 2'd0);
    // ptr == 2: requester 2 beats 0.
    cyc(4'b0101);
    expect_oe("rr_g2", 4'b0100, 2'd2);
    cyc(4'b0001);
    expect_oe("rr_turn2", 4'b0000, 2'd0);
    // ptr == 3: search wraps to 0.
    cyc(4'b0001);
    expect_oe("rr_wrap0", 4'b0001, 2'd0);
    cyc(4'b0000);
    cyc(4'b0000);
    expect_oe("rr_idle2", 4'b0000, 2'd0);

    // 5. Async reset mid-grant (ptr == 1, so requester 2 wins).
    cyc(4'b0100);
    expect_oe("ar_g2", 4'b0100, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    expect_oe("ar_async", 4'b0000, 2'd0);
    check_eq("ar_async.float", 32'(bus_float), 32'd1);
    #1;
    rst = 1'b0;
    req = 4'b1111;
    @(posedge clk);
    #1;
    expect_oe("ar_ptr0", 4'b0001, 2'd0);
    cyc(4'b0000);
    cyc(4'b0000);
    expect_oe("ar_idle", 4'b0000, 2'd0);

    // 4. All requesting, held: from reset ptr == 0.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < 70; t++) begin
      logic [3:0] e_oe;
      logic [1:0] e_id;
      cyc(4'b1111);
`ifdef TRISTATE_ARB_HOLD_LIMIT_EN
      if (t % 17 == 16) begin
        e_oe = 4'b0000;
        e_id = 2'd0;
      end else begin
        e_id = 2'((t / 17) % 4);
        e_oe = 4'b0001 << e_id;
      end
`else
      e_oe = 4'b0001;
      e_id = 2'd0;
`endif
      expect_oe("hold", e_oe, e_id);
    end
    cyc(4'b0000);
    cyc(4'b0000);
    cyc(4'b0000);
    expect_oe("hold_idle", 4'b0000, 2'd0);

    // 6. Random requests; invariants checked every cycle.
    for (int i = 0; i < 10000; i++) cyc(4'($urandom_range(0, 15)));
    cyc(4'b0000);
    cyc(4'b0000);
    cyc(4'b0000);
    expect_oe("rand_idle", 4'b0000, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_tristate_bus_arbiter
